// File: rtl/pipeline_stall_controller_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
package pipeline_stall_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FAULT    = 2'd2
  } stall_state_e;

  localparam int MEM_TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF       = 16;

  // Load in EX whose destination feeds an operand of the instruction in ID.
  // x0 is never a real dependency.
  function automatic logic is_load_use(input logic       mem_read,
                                       input logic [4:0] rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return mem_read && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count up on inc, hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Pipeline stall/flush controller: data-memory wait freeze with timeout,
// load-use interlock, taken-branch flush and performance counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal flow; load-use / branch / new memory wait evaluated
// ST_MEM_WAIT | pipeline frozen waiting on dmem_ready, wait_cnt counting
// ST_FAULT    | memory timed out; frozen with mem_fault until rst
//
// wait_cnt holds the number of MEM_WAIT cycles entered so far. Ready seen
// in the MEM_WAIT cycle where wait_cnt == MEM_TIMEOUT still releases; if it
// is still low there, the next cycle is FAULT.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_Rd,
  input  logic [4:0]       IF_ID_Rs1,
  input  logic [4:0]       IF_ID_Rs2,
  input  logic             branch_taken_ID,
  input  logic             EX_MEM_MemReq,
  input  logic             dmem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             EX_MEM_Write,
  output logic             MEM_WB_Flush,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  stall_state_e      state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_wait;
  logic              load_use;
  logic              stall_inc;
  logic              flush_inc;

  assign mem_wait = EX_MEM_MemReq && !dmem_ready;
  assign load_use = is_load_use(ID_EX_MemRead, ID_EX_Rd, IF_ID_Rs1, IF_ID_Rs2);

  // State and wait counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and pipeline control outputs; memory wait beats load-use
  // beats branch, and a masked event simply shows up again next cycle.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    PCWrite      = 1'b1;
    IF_ID_Write  = 1'b1;
    EX_MEM_Write = 1'b1;
    IF_ID_Flush  = 1'b0;
    ID_EX_Flush  = 1'b0;
    MEM_WB_Flush = 1'b0;

    if (rst) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
      IF_ID_Flush  = 1'b1;
      ID_EX_Flush  = 1'b1;
      MEM_WB_Flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN, ST_MEM_WAIT: begin
          if ((state_q == ST_RUN) ? mem_wait : !dmem_ready) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            EX_MEM_Write = 1'b0;
            MEM_WB_Flush = 1'b1;
            if (state_q == ST_RUN) begin
              state_d    = ST_MEM_WAIT;
              wait_cnt_d = WAIT_W'(1);
            end else if (wait_cnt_q == WAIT_W'(MEM_TIMEOUT)) begin
              state_d = ST_FAULT;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end else begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
            if (load_use) begin
              PCWrite     = 1'b0;
              IF_ID_Write = 1'b0;
              ID_EX_Flush = 1'b1;
            end else if (branch_taken_ID) begin
              IF_ID_Flush = 1'b1;
            end
          end
        end
        ST_FAULT: begin
          PCWrite      = 1'b0;
          IF_ID_Write  = 1'b0;
          EX_MEM_Write = 1'b0;
          MEM_WB_Flush = 1'b1;
        end
        default: begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      endcase
    end
  end

  assign mem_fault = (state_q == ST_FAULT);

  // Counter enables: FAULT freeze is not a stall, reset cycles count nothing.
  assign stall_inc = !rst && (state_q != ST_FAULT) && !PCWrite;
  assign flush_inc = !rst && (IF_ID_Flush || ID_EX_Flush);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MEM_TIMEOUT=15, CNT_W=4).
module tb_pipeline_stall_controller;

  localparam int TO = 15;
  localparam int CW = 4;

  // Output pack order: {PCWrite, IF_ID_Write, EX_MEM_Write, IF_ID_Flush,
  //                     ID_EX_Flush, MEM_WB_Flush, mem_fault}
  localparam logic [6:0] O_DEF = 7'b1110000;
  localparam logic [6:0] O_RST = 7'b0001110;
  localparam logic [6:0] O_FRZ = 7'b0000010;
  localparam logic [6:0] O_FLT = 7'b0000011;
  localparam logic [6:0] O_LU  = 7'b0010100;
  localparam logic [6:0] O_BR  = 7'b1111000;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_read;
  logic [4:0]    rd, rs1, rs2;
  logic          br, mreq, rdy;
  logic          pc_w, ifid_w, ifid_fl, idex_fl, exm_w, mwb_fl, fault;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_EX_MemRead   (mem_read),
    .ID_EX_Rd        (rd),
    .IF_ID_Rs1       (rs1),
    .IF_ID_Rs2       (rs2),
    .branch_taken_ID (br),
    .EX_MEM_MemReq   (mreq),
    .dmem_ready      (rdy),
    .PCWrite         (pc_w),
    .IF_ID_Write     (ifid_w),
    .IF_ID_Flush     (ifid_fl),
    .ID_EX_Flush     (idex_fl),
    .EX_MEM_Write    (exm_w),
    .MEM_WB_Flush    (mwb_fl),
    .mem_fault       (fault),
    .stall_count     (stall_cnt),
    .flush_count     (flush_cnt)
  );

  typedef struct {
    logic       rst, mr;
    logic [4:0] rd, rs1, rs2;
    logic       br, mreq, rdy;
    logic [6:0] outs;
    int         stall, flush;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic r, logic m, logic [4:0] d, logic [4:0] s1,
                              logic [4:0] s2, logic b, logic q, logic y,
                              logic [6:0] o, int sc, int fc);
    vec_t v;
    v.rst = r; v.mr = m; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.br = b; v.mreq = q; v.rdy = y; v.outs = o; v.stall = sc; v.flush = fc;
    return v;
  endfunction

  function automatic logic [6:0] outs();
    return {pc_w, ifid_w, exm_w, ifid_fl, idex_fl, mwb_fl, fault};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d (0x%0h) required=%0d (0x%0h)",
               name, $time, act, act, exp, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later,
  // well before the next rising edge.
  task automatic drive(input logic r, input logic m, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2,
                       input logic b, input logic q, input logic y);
    @(negedge clk);
    rst = r; mem_read = m; rd = d; rs1 = s1; rs2 = s2;
    br = b; mreq = q; rdy = y;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic chk_all(input string name, input logic [6:0] o, input int sc, input int fc);
    chk({name, ".outs"}, int'(outs()), int'(o));
    chk({name, ".stall"}, int'(stall_cnt), sc);
    chk({name, ".flush"}, int'(flush_cnt), fc);
  endtask

  initial begin
    // Counter values in each row are the ones visible before that row's edge.
    tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 1, O_RST, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 0, 0);
    tbl[2]  = mk(0, 1, 5, 7, 5, 0, 0, 1, O_LU,  0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 1, 1);
    tbl[4]  = mk(0, 1, 0, 0, 3, 0, 0, 1, O_DEF, 1, 1);
    tbl[5]  = mk(0, 0, 3, 3, 3, 0, 0, 1, O_DEF, 1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 1, 0, 1, O_BR,  1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, O_DEF, 1, 2);
    tbl[8]  = mk(0, 1, 9, 9, 2, 1, 0, 0, O_LU,  1, 2);
    tbl[9]  = mk(0, 0, 0, 0, 0, 1, 0, 1, O_BR,  2, 3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 2, 4);
    tbl[11] = mk(1, 1, 4, 4, 0, 1, 1, 0, O_RST, 2, 4);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, O_DEF, 0, 0);

    rst = 1'b1; mem_read = 1'b0; rd = '0; rs1 = '0; rs2 = '0;
    br = 1'b0; mreq = 1'b0; rdy = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst, tbl[i].mr, tbl[i].rd, tbl[i].rs1, tbl[i].rs2,
            tbl[i].br, tbl[i].mreq, tbl[i].rdy);
      chk_all($sformatf("vec%0d", i), tbl[i].outs, tbl[i].stall, tbl[i].flush);
    end

    // Memory wait of 3 cycles with a taken branch pending throughout.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0);
      chk_all($sformatf("mwait%0d", i), O_FRZ, i, 0);
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
    chk_all("mwait_release", O_BR, 3, 0);
    idle();
    chk_all("mwait_after", O_DEF, 3, 1);

    // Ready in the last allowed MEM_WAIT cycle (wait_cnt == TO) releases.
    do_reset();
    for (int i = 0; i <= TO; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, (i == TO) ? 1'b1 : 1'b0);
      chk($sformatf("edge_cyc%0d.outs", i), int'(outs()),
          int'((i == TO) ? O_DEF : O_FRZ));
    end
    idle();
    chk_all("edge_after", O_DEF, 15, 0);

    // Ready never comes: TO MEM_WAIT cycles after the first freeze, FAULT.
    do_reset();
    for (int i = 0; i <= TO; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("to_cyc%0d.outs", i), int'(outs()), int'(O_FRZ));
    end
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    chk_all("fault_entry", O_FLT, 15, 0);
    drive(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b1, 1'b0, 1'b1);
    chk_all("fault_hold_lu_br", O_FLT, 15, 0);
    idle();
    chk_all("fault_hold_idle", O_FLT, 15, 0);
    do_reset();
    chk("fault_rst.outs", int'(outs()), int'(O_RST | 7'b0000001));
    idle();
    chk_all("fault_cleared", O_DEF, 0, 0);

    // 20 back-to-back load-use stalls saturate the 4-bit counters at 15.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b1);
      chk($sformatf("sat_cyc%0d.outs", i), int'(outs()), int'(O_LU));
    end
    idle();
    chk_all("sat_final", O_DEF, 15, 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
